// File: rtl/bus_mem_slave.sv
// Bus-attached word memory with B/H/W loads and stores, misalignment and range checks.
// Ack comes WAIT_CYCLES+1 cycles after acceptance; no new request is taken until the ACK cycle ends.
module bus_mem_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          MEM_WORDS   = 1024,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_bus_en,
   input  logic        i_wr_rd,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wr_data,
   input  logic [2:0]  i_size,
   output logic        o_ack,
   output logic [31:0] o_rd_data,
   output logic        o_err
);

   localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [32:0] SPAN      = 33'(MEM_WORDS) << 2;
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   typedef struct packed {
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] data;
   } req_t;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t           state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   req_t             req_q, cur_req, acc;
   logic             acc_err, ack_err, mem_en, we;
   logic [3:0]       be;
   logic [31:0]      wlane;
   logic [IDX_W-1:0] widx;
   logic [31:0]      rd_word;
   logic [7:0]       rbyte;
   logic [15:0]      rhalf;
   logic [31:0]      mem [MEM_WORDS];

   // A 33-bit offset makes addresses below BASE_ADDR show up as a set borrow bit.
   function automatic logic access_err(input logic [31:0] addr, input logic [2:0] size);
      logic [32:0] off;
      logic        bad_size, misalign;
      off      = {1'b0, addr} - {1'b0, BASE_ADDR};
      bad_size = (size == 3'b011) || (size[2:1] == 2'b11);
      misalign = ((size[1:0] == 2'b01) && addr[0]) ||
                 ((size == 3'b010) && (addr[1:0] != 2'b00));
      return bad_size || misalign || off[32] || (off >= SPAN);
   endfunction

   assign cur_req = '{wr: i_wr_rd, size: i_size, addr: i_addr, data: i_wr_data};

   // With zero wait states the access happens on the accepting edge, before the latch is loaded.
   assign acc     = (state == IDLE) ? cur_req : req_q;
   assign acc_err = access_err(acc.addr, acc.size);
   assign widx    = IDX_W'((acc.addr - BASE_ADDR) >> 2);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && i_bus_en) begin
            req_q <= cur_req;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (i_bus_en) begin
               cnt_nxt   = WAIT_INIT;
               state_nxt = (WAIT_CYCLES > 0) ? WAIT : ACK;
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nxt = ACK;
            end
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The single memory access of a transaction happens on the edge entering ACK.
   assign mem_en = (state_nxt == ACK) && (state != ACK) && !acc_err && !i_rst;
   assign we     = mem_en && acc.wr;

   always_comb begin
      be    = 4'b0000;
      wlane = acc.data;
      case (acc.size[1:0])
         2'b00: begin
            be    = 4'b0001 << acc.addr[1:0];
            wlane = {4{acc.data[7:0]}};
         end
         2'b01: begin
            be    = acc.addr[1] ? 4'b1100 : 4'b0011;
            wlane = {2{acc.data[15:0]}};
         end
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++) begin
            if (we && be[b]) begin
               mem[widx][8*b +: 8] <= wlane[8*b +: 8];
            end
         end
         rd_word <= mem[widx];
      end
   end

   assign ack_err = access_err(req_q.addr, req_q.size);
   assign rbyte   = rd_word[{req_q.addr[1:0], 3'b000} +: 8];
   assign rhalf   = req_q.addr[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      o_ack     = (state == ACK);
      o_err     = (state == ACK) && ack_err;
      o_rd_data = '0;
      if ((state == ACK) && !ack_err && !req_q.wr) begin
         case (req_q.size)
            3'b000:  o_rd_data = {{24{rbyte[7]}}, rbyte};
            3'b001:  o_rd_data = {{16{rhalf[15]}}, rhalf};
            3'b010:  o_rd_data = rd_word;
            3'b100:  o_rd_data = {24'h0, rbyte};
            3'b101:  o_rd_data = {16'h0, rhalf};
            default: o_rd_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_mem_slave.sv
// Bench for bus_mem_slave: four instances with different wait counts against a byte-level reference memory.
module tb_bus_mem_slave;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          MW    = 16;
   localparam int          WAITS [4] = '{0, 1, 3, 5};

   logic        clk, rst;
   logic [3:0]  en;
   logic        wr_rd;
   logic [31:0] addr, wdata;
   logic [2:0]  size;
   logic [3:0]  ack, errv;
   logic [31:0] rdd [4];

   int errors = 0;
   int checks = 0;

   logic [7:0] mref [4][MW*4];

   bus_mem_slave #(.BASE_ADDR(BASE), .MEM_WORDS(MW), .WAIT_CYCLES(0)) u_w0 (
      .i_clk(clk), .i_rst(rst), .i_bus_en(en[0]), .i_wr_rd(wr_rd), .i_addr(addr),
      .i_wr_data(wdata), .i_size(size), .o_ack(ack[0]), .o_rd_data(rdd[0]), .o_err(errv[0]));
   bus_mem_slave #(.BASE_ADDR(BASE), .MEM_WORDS(MW), .WAIT_CYCLES(1)) u_w1 (
      .i_clk(clk), .i_rst(rst), .i_bus_en(en[1]), .i_wr_rd(wr_rd), .i_addr(addr),
      .i_wr_data(wdata), .i_size(size), .o_ack(ack[1]), .o_rd_data(rdd[1]), .o_err(errv[1]));
   bus_mem_slave #(.BASE_ADDR(BASE), .MEM_WORDS(MW), .WAIT_CYCLES(3)) u_w3 (
      .i_clk(clk), .i_rst(rst), .i_bus_en(en[2]), .i_wr_rd(wr_rd), .i_addr(addr),
      .i_wr_data(wdata), .i_size(size), .o_ack(ack[2]), .o_rd_data(rdd[2]), .o_err(errv[2]));
   bus_mem_slave #(.BASE_ADDR(BASE), .MEM_WORDS(MW), .WAIT_CYCLES(5)) u_w5 (
      .i_clk(clk), .i_rst(rst), .i_bus_en(en[3]), .i_wr_rd(wr_rd), .i_addr(addr),
      .i_wr_data(wdata), .i_size(size), .o_ack(ack[3]), .o_rd_data(rdd[3]), .o_err(errv[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Byte-addressed little-endian reference: size decides byte count, alignment is addr % count.
   task automatic model_access(input int idx, input bit wr, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] d,
                               output bit e, output logic [31:0] r);
      int     n;
      longint off, v;
      case (sz)
         3'd0, 3'd4: n = 1;
         3'd1, 3'd5: n = 2;
         3'd2:       n = 4;
         default:    n = 0;
      endcase
      off = longint'(a) - longint'(BASE);
      e   = (n == 0) || (off < 0) || (off >= MW * 4);
      if (!e && (a % n) != 0) e = 1'b1;
      r = 32'h0;
      if (e) return;
      if (wr) begin
         for (int k = 0; k < n; k++) mref[idx][int'(off) + k] = d[8*k +: 8];
      end else begin
         v = 0;
         for (int k = 0; k < n; k++) v += longint'(mref[idx][int'(off) + k]) << (8 * k);
         if ((sz == 3'd0 || sz == 3'd1) && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
         r = v[31:0];
      end
   endtask

   // Holds the request until ack, then checks latency, result, idle-time zeros and pulse width.
   task automatic do_txn(input string tag, input int idx, input bit wr, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd_o, output logic err_o);
      bit          exp_e, got;
      logic [31:0] exp_r;
      int          n, bad;
      model_access(idx, wr, sz, a, d, exp_e, exp_r);
      @(negedge clk);
      wr_rd = wr; size = sz; addr = a; wdata = d; en[idx] = 1'b1;
      n = 0; got = 1'b0; bad = 0;
      while (!got && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (ack[idx]) got = 1'b1;
         else if (rdd[idx] !== 32'h0 || errv[idx] !== 1'b0) bad++;
      end
      en[idx] = 1'b0;
      rd_o  = rdd[idx];
      err_o = errv[idx];
      chk({tag, "/ack_seen"}, 32'(got), 32'd1);
      chk({tag, "/latency"}, n, WAITS[idx] + 1);
      chk({tag, "/err"}, 32'(err_o), 32'(exp_e));
      chk({tag, "/rd_data"}, rd_o, exp_r);
      chk({tag, "/idle_zero"}, bad, 0);
      @(posedge clk); #1;
      chk({tag, "/ack_width"}, 32'(ack[idx]), 32'd0);
   endtask

   // Write on the WAIT_CYCLES=3 instance aborted by reset on edge rst_edge after acceptance.
   task automatic abort_txn(input int rst_edge, input logic [31:0] a, input logic [31:0] d,
                            output int acks);
      acks = 0;
      @(negedge clk);
      wr_rd = 1'b1; size = 3'b010; addr = a; wdata = d; en[2] = 1'b1;
      @(posedge clk); #1;
      en[2] = 1'b0;
      for (int k = 1; k <= rst_edge; k++) begin
         @(negedge clk);
         if (k == rst_edge) begin
            rst = 1'b1; en[2] = 1'b1;
         end
         @(posedge clk); #1;
         acks += int'(ack[2]);
      end
      @(negedge clk);
      rst = 1'b0; en[2] = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         acks += int'(ack[2]);
      end
   endtask

   initial begin
      logic [31:0] r;
      logic        e;
      int          acks, off;

      rst = 1'b1; en = '0; wr_rd = 1'b0; addr = '0; wdata = '0; size = 3'b010;
      for (int i = 0; i < 4; i++)
         for (int b = 0; b < MW * 4; b++) mref[i][b] = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset_ack%0d", i), 32'(ack[i]), 32'd0);
         chk($sformatf("reset_err%0d", i), 32'(errv[i]), 32'd0);
         chk($sformatf("reset_rd%0d", i), rdd[i], 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Preload every word of every instance so later reads have known contents.
      for (int w = 0; w < MW; w++)
         for (int i = 0; i < 4; i++)
            do_txn("preload", i, 1'b1, 3'b010, BASE + 32'(4 * w), $urandom, r, e);

      // Full-word round trip.
      do_txn("sw_dead", 1, 1'b1, 3'b010, BASE + 32'h10, 32'hDEADBEEF, r, e);
      do_txn("lw_dead", 1, 1'b0, 3'b010, BASE + 32'h10, 32'h0, r, e);
      chk("lw_dead_const", r, 32'hDEADBEEF);

      // Sub-word stores and signed/unsigned loads.
      do_txn("sw_zero", 1, 1'b1, 3'b010, BASE, 32'h0, r, e);
      do_txn("sb_80", 1, 1'b1, 3'b000, BASE + 32'h2, 32'hABCD_EF80, r, e);
      do_txn("sh_f00d", 1, 1'b1, 3'b001, BASE, 32'h1234_F00D, r, e);
      do_txn("lw_mix", 1, 1'b0, 3'b010, BASE, 32'h0, r, e);
      chk("lw_mix_const", r, 32'h0080F00D);
      do_txn("lb_2", 1, 1'b0, 3'b000, BASE + 32'h2, 32'h0, r, e);
      chk("lb_2_const", r, 32'hFFFFFF80);
      do_txn("lbu_2", 1, 1'b0, 3'b100, BASE + 32'h2, 32'h0, r, e);
      chk("lbu_2_const", r, 32'h00000080);
      do_txn("lh_0", 1, 1'b0, 3'b001, BASE, 32'h0, r, e);
      chk("lh_0_const", r, 32'hFFFFF00D);
      do_txn("lhu_0", 1, 1'b0, 3'b101, BASE, 32'h0, r, e);
      chk("lhu_0_const", r, 32'h0000F00D);

      // Rejected accesses, then confirm no word moved.
      do_txn("err_lw2", 1, 1'b0, 3'b010, BASE + 32'h2, 32'h0, r, e);
      chk("err_lw2_flag", 32'(e), 32'd1);
      do_txn("err_sh1", 1, 1'b1, 3'b001, BASE + 32'h1, 32'hFFFF_FFFF, r, e);
      chk("err_sh1_flag", 32'(e), 32'd1);
      do_txn("err_sz3", 1, 1'b1, 3'b011, BASE + 32'h4, 32'hFFFF_FFFF, r, e);
      do_txn("err_end", 1, 1'b1, 3'b010, BASE + 32'(4 * MW), 32'hFFFF_FFFF, r, e);
      chk("err_end_flag", 32'(e), 32'd1);
      do_txn("err_below", 1, 1'b1, 3'b010, BASE - 32'h4, 32'hFFFF_FFFF, r, e);
      for (int w = 0; w < MW; w++)
         do_txn($sformatf("after_err_w%0d", w), 1, 1'b0, 3'b010, BASE + 32'(4 * w), 32'h0, r, e);

      // Latency sweep, two back-to-back requests per instance.
      for (int i = 0; i < 4; i++) begin
         do_txn($sformatf("lat%0d_a", WAITS[i]), i, 1'b0, 3'b010, BASE + 32'h8, 32'h0, r, e);
         do_txn($sformatf("lat%0d_b", WAITS[i]), i, 1'b0, 3'b010, BASE + 32'hC, 32'h0, r, e);
      end

      // Reset in the second WAIT cycle, and on the edge that would enter ACK.
      do_txn("pre_abort", 2, 1'b1, 3'b010, BASE + 32'h20, 32'hAAAAAAAA, r, e);
      abort_txn(2, BASE + 32'h20, 32'h12345678, acks);
      chk("abort_wait_acks", acks, 0);
      do_txn("abort_wait_lw", 2, 1'b0, 3'b010, BASE + 32'h20, 32'h0, r, e);
      chk("abort_wait_const", r, 32'hAAAAAAAA);
      abort_txn(3, BASE + 32'h20, 32'h12345678, acks);
      chk("abort_ack_acks", acks, 0);
      do_txn("abort_ack_lw", 2, 1'b0, 3'b010, BASE + 32'h20, 32'h0, r, e);
      chk("abort_ack_const", r, 32'hAAAAAAAA);

      // Inputs move and the request drops right after acceptance.
      @(negedge clk);
      wr_rd = 1'b1; size = 3'b010; addr = BASE + 32'h24; wdata = 32'h5555AAAA; en[2] = 1'b1;
      model_access(2, 1'b1, 3'b010, BASE + 32'h24, 32'h5555AAAA, e, r);
      @(posedge clk); #1;
      addr = BASE + 32'h28; wdata = 32'h11111111; en[2] = 1'b0;
      acks = 0;
      repeat (10) begin
         @(posedge clk); #1;
         acks += int'(ack[2]);
      end
      chk("latch_acks", acks, 1);
      do_txn("latch_lw24", 2, 1'b0, 3'b010, BASE + 32'h24, 32'h0, r, e);
      chk("latch_lw24_const", r, 32'h5555AAAA);
      do_txn("latch_lw28", 2, 1'b0, 3'b010, BASE + 32'h28, 32'h0, r, e);

      // Random mix across all instances, sizes and a window reaching past both ends.
      for (int t = 0; t < 60; t++) begin
         int idx;
         idx = $urandom_range(0, 3);
         off = int'($urandom_range(0, 75)) - 4;
         do_txn($sformatf("rand%0d", t), idx, 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), BASE + 32'(off), $urandom, r, e);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
